// File: rtl/rob_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : rob_pkg                                                  |
// | Purpose : Shared types, widths and helpers for the read-ID         |
// |           allocator / restore pair.                                |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
package rob_pkg;

  // Widths the beat struct is built from; the restore block defaults to these.
  localparam int RB_ID_W   = 4;
  localparam int RB_DATA_W = 64;
  localparam int RB_RESP_W = 2;

  // max(1, clog2(n)): a single row/column still needs one index bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width of the compressed {row, col} unique ID.
  function automatic int uid_width(input int rows, input int cols);
    return idx_width(rows) + idx_width(cols);
  endfunction

  typedef struct packed {
    logic [RB_ID_W-1:0]   id;
    logic [RB_DATA_W-1:0] data;
    logic [RB_RESP_W-1:0] resp;
    logic                 last;
  } r_beat_t;

  // FIRST: next beat opens a burst; BURST: inside a multi-beat burst.
  typedef enum logic [0:0] {
    FIRST = 1'b0,
    BURST = 1'b1
  } r_state_e;

endpackage
`default_nettype wire

// File: rtl/r_skid_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : r_skid_buffer                                            |
// | Purpose : 2-entry valid/ready FIFO of R beats; the head entry      |
// |           drives the output side directly.                         |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module r_skid_buffer
  import rob_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    in_valid,
  output logic    in_ready,
  input  r_beat_t in_beat,
  output logic    out_valid,
  input  logic    out_ready,
  output r_beat_t out_beat
);

  logic [1:0] r_count;
  logic       r_ready;
  r_beat_t    r_head;
  r_beat_t    r_tail;

  logic       w_push;
  logic       w_pop;
  logic [1:0] w_count_next;

  // Ready is registered so it stays low through reset and rises one cycle later.
  assign w_push    = in_valid && r_ready;
  assign w_pop     = (r_count != 2'd0) && out_ready;
  assign in_ready  = r_ready;
  assign out_valid = (r_count != 2'd0);
  assign out_beat  = r_head;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 2'd1;
      2'b01:   w_count_next = r_count - 2'd1;
      default: w_count_next = r_count;
    endcase
  end

  // Storage update; the head shifts from the tail when a full buffer pops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= 2'd0;
      r_ready <= 1'b0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      r_count <= w_count_next;
      r_ready <= (w_count_next != 2'd2);
      if (w_pop) begin
        if (r_count == 2'd2) begin
          r_head <= r_tail;
        end else if (w_push) begin
          r_head <= in_beat;
        end
      end else if (w_push) begin
        if (r_count == 2'd0) begin
          r_head <= in_beat;
        end else begin
          r_tail <= in_beat;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/r_id_restore.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : r_id_restore                                             |
// | Purpose : Restores the original AXI RID on returning R beats,      |
// |           releasing the compressed UID once per burst.             |
// |           Optional checker enabled by macro ROB_RESP_CHECK_EN.     |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module r_id_restore
  import rob_pkg::*;
#(
  parameter int ID_WIDTH   = RB_ID_W,
  parameter int NUM_ROWS   = 4,
  parameter int NUM_COLS   = 4,
  parameter int DATA_WIDTH = RB_DATA_W,
  parameter int RESP_WIDTH = RB_RESP_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_rvalid,
  output logic                        s_rready,
  input  logic [uid_width(NUM_ROWS, NUM_COLS)-1:0] s_rid,
  input  logic [DATA_WIDTH-1:0]       s_rdata,
  input  logic [RESP_WIDTH-1:0]       s_rresp,
  input  logic                        s_rlast,
  output logic                        m_rvalid,
  input  logic                        m_rready,
  output logic [ID_WIDTH-1:0]         m_rid,
  output logic [DATA_WIDTH-1:0]       m_rdata,
  output logic [RESP_WIDTH-1:0]       m_rresp,
  output logic                        m_rlast,
  output logic                        free_req,
  output logic [uid_width(NUM_ROWS, NUM_COLS)-1:0] free_unique_id,
  input  logic [ID_WIDTH-1:0]         restored_id,
  input  logic                        free_ack,
  output logic                        err
);

  localparam int UID_W = uid_width(NUM_ROWS, NUM_COLS);

  r_state_e            r_state;
  r_state_e            w_state_next;
  logic [ID_WIDTH-1:0] r_burst_id;

  logic    w_skid_ready;
  logic    w_accept;
  logic    w_first;
  r_beat_t w_beat;
  r_beat_t w_head;

  assign s_rready = w_skid_ready;
  assign w_accept = s_rvalid && w_skid_ready;
  assign w_first  = (r_state == FIRST);

  // Next state, free request and the ID mux for the incoming beat.
  always_comb begin
    w_state_next   = r_state;
    free_req       = 1'b0;
    free_unique_id = '0;
    w_beat         = '0;
    w_beat.data    = s_rdata;
    w_beat.resp    = s_rresp;
    w_beat.last    = s_rlast;
    w_beat.id      = r_burst_id;
    case (r_state)
      FIRST: begin
        w_beat.id = restored_id;
        if (w_accept) begin
          free_req       = 1'b1;
          free_unique_id = s_rid;
          w_state_next   = s_rlast ? FIRST : BURST;
        end
      end
      BURST: begin
        if (w_accept && s_rlast) begin
          w_state_next = FIRST;
        end
      end
      default: w_state_next = FIRST;
    endcase
  end

  // State register and the ID captured when a burst opens.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= FIRST;
      r_burst_id <= '0;
    end else begin
      r_state <= w_state_next;
      if (free_req) begin
        r_burst_id <= restored_id;
      end
    end
  end

  r_skid_buffer u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s_rvalid),
    .in_ready  (w_skid_ready),
    .in_beat   (w_beat),
    .out_valid (m_rvalid),
    .out_ready (m_rready),
    .out_beat  (w_head)
  );

  assign m_rid   = w_head.id;
  assign m_rdata = w_head.data;
  assign m_rresp = w_head.resp;
  assign m_rlast = w_head.last;

`ifdef ROB_RESP_CHECK_EN
  logic [UID_W-1:0] r_burst_uid;
  logic             r_free_req_d;
  logic             r_err;

  // Sticky error: UID changes mid-burst, or ack does not follow free by one cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_burst_uid  <= '0;
      r_free_req_d <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_free_req_d <= free_req;
      if (free_req) begin
        r_burst_uid <= s_rid;
      end
      if ((w_accept && !w_first && (s_rid != r_burst_uid)) ||
          (free_ack != r_free_req_d)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err = r_err;
`else
  logic w_unused_free_ack;
  assign w_unused_free_ack = free_ack;
  assign err               = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_r_id_restore.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tb_r_id_restore                                          |
// | Purpose : Self-checking bench for r_id_restore with a queue-based  |
// |           reference model of the beat stream.                      |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module tb_r_id_restore;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_rvalid = 1'b0;
  logic        s_rready;
  logic [3:0]  s_rid = '0;
  logic [63:0] s_rdata = '0;
  logic [1:0]  s_rresp = '0;
  logic        s_rlast = 1'b0;
  logic        m_rvalid;
  logic        m_rready = 1'b0;
  logic [3:0]  m_rid;
  logic [63:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast;
  logic        free_req;
  logic [3:0]  free_unique_id;
  logic [3:0]  restored_id = '0;
  logic        free_ack = 1'b0;
  logic        err;

  r_id_restore dut (
    .clk            (clk),
    .rst            (rst),
    .s_rvalid       (s_rvalid),
    .s_rready       (s_rready),
    .s_rid          (s_rid),
    .s_rdata        (s_rdata),
    .s_rresp        (s_rresp),
    .s_rlast        (s_rlast),
    .m_rvalid       (m_rvalid),
    .m_rready       (m_rready),
    .m_rid          (m_rid),
    .m_rdata        (m_rdata),
    .m_rresp        (m_rresp),
    .m_rlast        (m_rlast),
    .free_req       (free_req),
    .free_unique_id (free_unique_id),
    .restored_id    (restored_id),
    .free_ack       (free_ack),
    .err            (err)
  );

  always #5 clk = ~clk;

  // Allocator stand-in: acks one cycle after each free unless withheld.
  logic ack_en = 1'b1;
  always @(posedge clk) free_ack <= ack_en && free_req;

  typedef struct {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } exp_t;

  exp_t       q[$];
  bit         mdl_in_burst = 1'b0;
  logic [3:0] mdl_burst_id = '0;
  logic [3:0] mdl_burst_uid = '0;
  bit         mdl_prev_free = 1'b0;
  bit         mdl_err = 1'b0;
  bit         acc = 1'b0;
  int         n_pass = 0;
  int         n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [3:0] rid, input logic last,
                       input logic [3:0] rest);
    s_rvalid    = v;
    s_rid       = rid;
    s_rdata     = {$urandom, $urandom};
    s_rresp     = 2'($urandom_range(0, 3));
    s_rlast     = last;
    restored_id = rest;
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model.
  task automatic cycle();
    bit   exp_ready;
    bit   exp_valid;
    bit   exp_free;
    bit   pop;
    exp_t b;
    #3;
    exp_ready = (q.size() < 2);
    exp_valid = (q.size() != 0);
    acc       = s_rvalid && exp_ready;
    exp_free  = acc && !mdl_in_burst;
    chk("s_rready", s_rready, exp_ready);
    chk("m_rvalid", m_rvalid, exp_valid);
    if (exp_valid) begin
      chk("m_rid", m_rid, q[0].id);
      chk("m_rdata", m_rdata, q[0].data);
      chk("m_rresp", m_rresp, q[0].resp);
      chk("m_rlast", m_rlast, q[0].last);
    end
    chk("free_req", free_req, exp_free);
    if (exp_free) chk("free_unique_id", free_unique_id, s_rid);
    chk("err", err, mdl_err);
    pop = exp_valid && m_rready;
`ifdef ROB_RESP_CHECK_EN
    if (free_ack != mdl_prev_free) mdl_err = 1'b1;
    if (acc && mdl_in_burst && (s_rid != mdl_burst_uid)) mdl_err = 1'b1;
`endif
    mdl_prev_free = exp_free;
    if (pop) void'(q.pop_front());
    if (acc) begin
      if (!mdl_in_burst) begin
        mdl_burst_id  = restored_id;
        mdl_burst_uid = s_rid;
      end
      b.id   = mdl_burst_id;
      b.data = s_rdata;
      b.resp = s_rresp;
      b.last = s_rlast;
      q.push_back(b);
      mdl_in_burst = !s_rlast;
    end
    @(posedge clk);
    #1;
  endtask

  // Offer one beat until accepted, within a cycle budget.
  task automatic send(input logic [3:0] rid, input logic last, input logic [3:0] rest);
    int n;
    drive(1'b1, rid, last, rest);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!acc && n < 20);
    if (!acc) begin
      n_total++;
      $error("FAIL send_timeout observed=not_accepted expected=accepted");
    end
    s_rvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    s_rvalid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         st_left;
    logic [3:0] st_uid;
    bit         pending;

    // Reset hold with a beat offered: nothing may move.
    drive(1'b1, 4'b1001, 1'b1, 4'hA);
    m_rready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_rready", s_rready, 1'b0);
    chk("rst_m_rvalid", m_rvalid, 1'b0);
    chk("rst_m_rid", m_rid, 4'h0);
    chk("rst_m_rdata", m_rdata, 64'h0);
    chk("rst_m_rresp", m_rresp, 2'h0);
    chk("rst_m_rlast", m_rlast, 1'b0);
    chk("rst_free_req", free_req, 1'b0);
    chk("rst_free_uid", free_unique_id, 4'h0);
    chk("rst_err", err, 1'b0);
    rst = 1'b1;
    #3;
    chk("rel_s_rready", s_rready, 1'b0);
    chk("rel_free_req", free_req, 1'b0);
    @(posedge clk);
    #1;

    // Single-beat burst, restored ID 0xA.
    send(4'b1001, 1'b1, 4'hA);
    idle(2);

    // 4-beat burst: only beat 0 frees, later restored_id values ignored.
    send(4'b0110, 1'b0, 4'h3);
    send(4'b0110, 1'b0, 4'hF);
    send(4'b0110, 1'b0, 4'hF);
    send(4'b0110, 1'b1, 4'hF);
    idle(2);

    // Back-pressure: two beats fill the buffer, the third waits.
    m_rready = 1'b0;
    send(4'b0010, 1'b0, 4'h7);
    send(4'b0010, 1'b0, 4'h1);
    drive(1'b1, 4'b0010, 1'b1, 4'h1);
    for (int i = 0; i < 3; i++) cycle();
    m_rready = 1'b1;
    send(4'b0010, 1'b1, 4'h9);
    idle(3);

    // Back-to-back single-beat bursts free on consecutive cycles.
    send(4'd0, 1'b1, 4'h4);
    send(4'd1, 1'b1, 4'h5);
    send(4'd2, 1'b1, 4'h6);
    idle(2);

    // Randomized bursts with random gaps and back-pressure.
    st_left = 0;
    st_uid  = '0;
    pending = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!pending) begin
        if ($urandom_range(0, 3) != 0) begin
          if (st_left == 0) begin
            st_left = $urandom_range(1, 4);
            st_uid  = 4'($urandom);
          end
          drive(1'b1, st_uid, (st_left == 1), 4'($urandom));
          pending = 1'b1;
        end else begin
          s_rvalid = 1'b0;
        end
      end
      restored_id = 4'($urandom);
      m_rready    = ($urandom_range(0, 2) != 0);
      cycle();
      if (acc) begin
        pending  = 1'b0;
        s_rvalid = 1'b0;
        st_left--;
      end
    end
    m_rready = 1'b1;
    while (st_left > 0) begin
      send(st_uid, (st_left == 1), 4'($urandom));
      st_left--;
    end
    idle(3);

    // Allocator withholds the ack for one free.
    ack_en = 1'b0;
    send(4'b1100, 1'b1, 4'h2);
    ack_en = 1'b1;
    idle(2);

    // UID changes in the middle of a burst.
    send(4'b0110, 1'b0, 4'h8);
    send(4'b0111, 1'b1, 4'h0);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/r_id_restore.md
Name: r_id_restore

Overview:
- Response-side counterpart of the read-ID allocator. It accepts R beats from the downstream slave, tagged with the compressed unique ID (UID = {row, col}), and returns them upstream with the original AXI ID restored.
- It drives the allocator's free interface once per burst, capturing restored_id, and buffers beats through a 2-entry skid for full throughput.
- It sits between the downstream R channel and the upstream master R channel.

Parameters:
- ID_WIDTH, 4, original AXI ARID/RID width.
- NUM_ROWS, 4, allocator rows.
- NUM_COLS, 4, allocator columns per row.
- DATA_WIDTH, 64, RDATA width.
- RESP_WIDTH, 2, RRESP width.
- Derived, not overridable: ROW_W = max(1, clog2(NUM_ROWS)), COL_W = max(1, clog2(NUM_COLS)), UID_W = ROW_W + COL_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-low reset.
- s_rvalid  in  1  downstream beat valid.
- s_rready  out  1  downstream beat ready.
- s_rid  in  UID_W  unique ID of beat.
- s_rdata  in  DATA_WIDTH  read data.
- s_rresp  in  RESP_WIDTH  response code.
- s_rlast  in  1  last beat of burst.
- m_rvalid  out  1  upstream beat valid.
- m_rready  in  1  upstream beat ready.
- m_rid  out  ID_WIDTH  restored original ID.
- m_rdata  out  DATA_WIDTH  read data.
- m_rresp  out  RESP_WIDTH  response code.
- m_rlast  out  1  last beat.
- free_req  out  1  release UID in allocator.
- free_unique_id  out  UID_W  UID being released.
- restored_id  in  ID_WIDTH  original ID returned combinationally by allocator while free_req=1.
- free_ack  in  1  allocator ack, one cycle after free_req.
- err  out  1  sticky protocol error; only meaningful with the optional feature.

Behaviour:
- One clock (clk); reset is synchronous, active-low on rst.
- Reset values: s_rready=0, m_rvalid=0, m_rid/m_rdata/m_rresp/m_rlast=0, free_req=0, free_unique_id=0, err=0.
- Reset forces FSM=FIRST, skid empty, burst_id_q=0.
- s_rready rises the first cycle after reset deasserts.
- Accept condition: s_rvalid && s_rready. s_rready = skid not full (fewer than 2 entries).
- FSM FIRST (next beat opens a burst):
  - On accept: free_req=1 and free_unique_id=s_rid, same cycle, combinationally.
  - The beat is stored with id=restored_id, and restored_id is latched into burst_id_q.
  - If s_rlast=1, stay in FIRST; else go to BURST.
- FSM BURST:
  - On accept: store beat with id=burst_id_q; free_req=0.
  - If s_rlast=1, go to FIRST.
- free_req is never asserted without an accept in FIRST, and is at most 1 per cycle. Single-beat bursts can therefore free on consecutive cycles.
- Skid buffer:
  - 2-entry FIFO; head drives the m_* outputs.
  - Latency is 1 cycle from accept to m_rvalid when empty.
  - Simultaneous push and pop when full: pop occurs, but s_rready was already 0 that cycle, so no push.
  - Simultaneous push and pop with 1 entry: count stays 1.
- m_* outputs are stable while m_rvalid && !m_rready.
- UID decode is not performed here; the UID is passed opaquely to the allocator.
- Bursts from downstream are contiguous (no read interleaving). This is a system contract.
- Without the optional feature, free_ack is ignored.
- Reset mid-burst: buffered beats are discarded and the FSM returns to FIRST. The freed UID state is owned by the allocator, which is reset together with this block.

Optional Feature:
- Macro: ROB_RESP_CHECK_EN.
- Defined: err sets (sticky until reset) on any of:
  - (a) BURST-state accept with s_rid != UID latched at burst start;
  - (b) free_ack=1 when free_req was 0 the previous cycle;
  - (c) free_ack=0 the cycle after free_req=1.
- Defined: this adds a UID_W register for the burst UID and a 1-bit free_req delay.
- Not defined: err tied 0, free_ack unused, no extra registers.

Decomposition:
- Package rob_pkg:
  - uid_width function (shared with the allocator);
  - typedef r_beat_t struct {id, data, resp, last}, parameterised via package localparams;
  - FSM enum {FIRST, BURST}.
- Sub-module: r_skid_buffer (2-entry valid/ready FIFO of r_beat_t).
- FSM, free generation and the ID mux stay in r_id_restore.

Test Plan:
- Reset hold then release with s_rvalid=1 → s_rready=0 during reset, 1 the next cycle; all outputs 0 during reset.
- Single beat s_rid=4'b1001, rlast=1, allocator restored_id=4'hA, m_rready=1:
  - free_req=1 with free_unique_id=4'b1001 in the accept cycle;
  - the next cycle m_rvalid=1, m_rid=4'hA, m_rlast=1.
- 4-beat burst s_rid=4'b0110, restored_id=4'h3 on beat 0 and restored_id driven to 4'hF afterwards → exactly one free_req (beat 0); all 4 m beats show m_rid=4'h3.
- m_rready=0 with 3 beats offered → 2 accepted, then s_rready=0; m_* held stable; after release the beats drain in order, and 1 cycle later s_rready=1.
- Back-to-back single-beat bursts UIDs 0,1,2 with m_rready=1 → free_req high 3 consecutive cycles; no bubbles on m_rvalid.
- With ROB_RESP_CHECK_EN: mid-burst s_rid change 4'b0110→4'b0111 → err=1 next cycle and stays 1. Separately, free_ack withheld after free_req → err=1.
